repl_multi: RTL
===============

Name: repl_multi

Overview:
- Per-set cache-way replacement selector for set-associative caches, generalising the free-running round-robin victim counter.
- Holds per-set state for SET_NUM sets. Supports three run-time-fixed policies: per-set round-robin, global LFSR random, and tree pseudo-LRU.
- Always prefers an invalid way over the policy choice.
- Sits beside the tag/valid arrays in the I/D cache controllers. Victim lookup is combinational; state updates take effect on the next clock edge.

Parameters:
- SET_ASSOC, 4, number of ways. Power of two, at least 1.
- SET_NUM, 64, number of sets. Power of two, at least 2.
- POLICY, REPL_PLRU, policy select (repl_policy_t): REPL_RR, REPL_RAND or REPL_PLRU.
- LFSR_SEED, 16'hACE1, LFSR reset value. Must be non-zero.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- lookup_set  in  $clog2(SET_NUM)  set being looked up for a victim.
- way_valid  in  SET_ASSOC  valid bits of the ways in lookup_set.
- repl_index  out  max(1,$clog2(SET_ASSOC))  chosen victim way.
- update  in  1  commit an access or fill to update_set.
- fill  in  1  qualifies update as a refill (advances RR).
- update_set  in  $clog2(SET_NUM)  set being updated.
- access  in  SET_ASSOC  one-hot way accessed or filled.

Behaviour:
- Reset (rst=1 at an edge):
  - all per-set RR pointers and all PLRU tree bits clear to 0;
  - LFSR loads LFSR_SEED.
  - repl_index is then 0 for POLICY=RR or PLRU with all ways valid. Reset overrides a concurrent update.
- Victim selection (combinational, 0 latency):
  - If way_valid is not all ones, repl_index = lowest-numbered invalid way.
  - Otherwise repl_index is the policy choice from the current state of lookup_set.
- RR:
  - per set, a $clog2(SET_ASSOC)-bit pointer; choice = pointer.
  - On update & fill & (access != 0), the pointer of update_set becomes pointer+1, wrapping modulo SET_ASSOC.
  - update without fill leaves the pointer unchanged.
- RAND:
  - one global 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Shifts every cycle out of reset, independent of update. Choice = LFSR[$clog2(SET_ASSOC)-1:0].
  - update, fill, access and update_set are ignored.
- PLRU:
  - per set, SET_ASSOC-1 tree bits, heap order: root is node 0; children of node i are 2i+1 and 2i+2.
  - Victim walk: at each node, bit 0 goes to the lower half, bit 1 to the upper half.
  - On update & (access != 0), each node on the path to the accessed way is set to point away from it: bit = 1 if the way is in the lower half, else 0. Nodes off the path are unchanged.
  - fill is ignored.
- access handling: if access has more than one bit set, the lowest set bit is used. If access == 0, update is a no-op.
- Simultaneous update and lookup of the same set: repl_index reflects the pre-update state; the new state is visible in the following cycle.
- SET_ASSOC == 1: repl_index is constantly 0 and no per-set state is built. The RAND LFSR may still be built, but its output is unused.
- Per-set state is held in flops, with one write port (update_set) and one read port (lookup_set).

Decomposition:
- Package repl_defs_pkg:
  - repl_policy_t enum {REPL_RR, REPL_RAND, REPL_PLRU};
  - LFSR_WIDTH = 16, LFSR_MASK = 16'hB400;
  - functions onehot_to_index (lowest set bit) and first_zero (lowest invalid way).
- Sub-module repl_plru_tree: purely combinational, parameter SET_ASSOC.
  - Input tree bits; outputs the victim index.
  - Input an accessed index; outputs the next tree bits.
  - repl_multi instantiates it once for the lookup path and once for the update path.

Test Plan:
- PLRU, 4 ways, after reset, way_valid=4'b1111 → repl_index=0. update, access=4'b0001, set 5; next cycle lookup_set=5 → 2. Then access=4'b0100 → 1. Lookup of set 6 still → 0.
- Invalid priority: way_valid=4'b1011, any policy → repl_index=2. way_valid=4'b0000 → 0.
- RR: three fills to set 3 (update=1, fill=1) → lookups return 0, 1, 2, 3. A fourth fill wraps back to 0. An update with fill=0 leaves the pointer unchanged.
- RAND: from seed 16'hACE1, check the repl_index sequence against a reference-model LFSR for 100 cycles. update has no effect. Reset mid-run restarts the sequence at seed low bits (2'b01).
- Same-cycle hazard: in PLRU, update of set 7 with access=4'b0001 while lookup_set=7 → repl_index=0 this cycle, 2 the next.
- Reset mid-operation: assert rst in the same cycle as update on set 2 → after reset, set 2 returns 0 and the update is discarded. Multi-hot access=4'b1100 → treated as way 2.

Source files
------------

// File: rtl/repl_defs_pkg.sv
// Shared definitions for the cache-way replacement selector.
//   repl_policy_t   : run-time-fixed replacement policy
//   LFSR_WIDTH/MASK : global Galois LFSR used by the random policy
//   onehot_to_index : index of the lowest set bit of a way vector
//   first_zero      : index of the lowest clear bit (lowest invalid way)
package repl_defs_pkg;

  typedef enum logic [1:0] {
    REPL_RR   = 2'd0,
    REPL_RAND = 2'd1,
    REPL_PLRU = 2'd2
  } repl_policy_t;

  localparam int          LFSR_WIDTH = 16;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

  // Widest way vector the helper functions accept; callers zero-extend.
  localparam int MAX_WAYS = 64;

  // Lowest set bit wins, so a multi-hot vector resolves to its lowest way.
  function automatic int onehot_to_index(input logic [MAX_WAYS-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int first_zero(input logic [MAX_WAYS-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (!v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/repl_plru_tree.sv
// Combinational tree pseudo-LRU helper for one set.
//   tree_bits  in  SET_ASSOC-1 tree bits, heap order (node 0 is the root,
//                  children of node i are 2i+1 and 2i+2)
//   victim     out way reached by walking the tree (0 = lower half)
//   access_idx in  way being accessed
//   next_bits  out tree bits after the access: every node on the path to
//                  access_idx points away from it, other nodes unchanged
// Requires SET_ASSOC >= 2 and a power of two.
module repl_plru_tree #(
  parameter  int SET_ASSOC = 4,
  localparam int IDX_W     = $clog2(SET_ASSOC)
) (
  input  logic [SET_ASSOC-2:0] tree_bits,
  output logic [IDX_W-1:0]     victim,
  input  logic [IDX_W-1:0]     access_idx,
  output logic [SET_ASSOC-2:0] next_bits
);

  localparam int LVL    = IDX_W;
  localparam int NODE_W = IDX_W + 1;

  // Padded copy so the walk's node index (which can step one level past
  // the leaves on the final iteration) always addresses a real bit.
  logic [2*SET_ASSOC-1:0] walk_bits;
  assign walk_bits = {{(SET_ASSOC + 1){1'b0}}, tree_bits};

  always_comb begin
    logic [NODE_W-1:0] node;
    logic              b;
    node   = '0;
    victim = '0;
    for (int l = 0; l < LVL; l++) begin
      b      = walk_bits[node];
      victim = (victim << 1) | IDX_W'(b);
      node   = (node << 1) + NODE_W'(1) + NODE_W'(b);
    end
  end

  // Node k at level l lies on the path of way a exactly when the top l
  // bits of a equal k; the next bit of a says which half the way is in.
  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    for (genvar k = 0; k < (1 << l); k++) begin : g_node
      localparam int NODE = (1 << l) - 1 + k;
      assign next_bits[NODE] = ((access_idx >> (LVL - l)) == IDX_W'(k))
                               ? ~access_idx[LVL-1-l]
                               : tree_bits[NODE];
    end
  end

endmodule

// File: rtl/repl_multi.sv
// Per-set cache-way replacement selector.
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   lookup_set in  set being looked up for a victim
//   way_valid  in  valid bits of the ways in lookup_set
//   repl_index out victim way (combinational from lookup_set/way_valid)
//   update     in  commit an access or fill to update_set
//   fill       in  qualifies update as a refill (advances round-robin)
//   update_set in  set being updated
//   access     in  one-hot way accessed/filled (lowest bit used if multi-hot)
// An invalid way always wins over the policy choice. State written by an
// update is visible to lookups from the next cycle on.
module repl_multi
  import repl_defs_pkg::*;
#(
  parameter  int           SET_ASSOC = 4,
  parameter  int           SET_NUM   = 64,
  parameter  repl_policy_t POLICY    = REPL_PLRU,
  parameter  logic [15:0]  LFSR_SEED = 16'hACE1,
  localparam int           SET_W     = $clog2(SET_NUM),
  localparam int           IDX_W     = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_W-1:0]     lookup_set,
  input  logic [SET_ASSOC-1:0] way_valid,
  output logic [IDX_W-1:0]     repl_index,
  input  logic                 update,
  input  logic                 fill,
  input  logic [SET_W-1:0]     update_set,
  input  logic [SET_ASSOC-1:0] access
);

  // Not every policy consumes every input.
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, lookup_set, way_valid, update, fill,
                           update_set, access};

  if (SET_ASSOC == 1) begin : g_one_way
    assign repl_index = '0;
  end else begin : g_ways
    logic [IDX_W-1:0] policy_idx;

    if (POLICY == REPL_RR) begin : g_rr
      logic [IDX_W-1:0] rr_ptr [SET_NUM];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SET_NUM; s++) rr_ptr[s] <= '0;
        end else if (update && fill && (|access)) begin
          // Power-of-two way count: natural overflow is the modulo wrap.
          rr_ptr[update_set] <= rr_ptr[update_set] + IDX_W'(1);
        end
      end

      assign policy_idx = rr_ptr[lookup_set];

    end else if (POLICY == REPL_RAND) begin : g_rand
      logic [LFSR_WIDTH-1:0] lfsr;

      // Galois form, shifting right; free-running, unaffected by updates.
      always_ff @(posedge clk) begin
        if (rst) begin
          lfsr <= LFSR_SEED;
        end else if (lfsr[0]) begin
          lfsr <= (lfsr >> 1) ^ LFSR_MASK;
        end else begin
          lfsr <= lfsr >> 1;
        end
      end

      assign policy_idx = lfsr[IDX_W-1:0];

    end else begin : g_plru
      logic [SET_ASSOC-2:0] tree [SET_NUM];
      logic [IDX_W-1:0]     acc_idx;
      logic [SET_ASSOC-2:0] tree_next;
      logic [SET_ASSOC-2:0] lookup_next_unused;
      logic [IDX_W-1:0]     update_victim_unused;

      assign acc_idx = IDX_W'(onehot_to_index(MAX_WAYS'(access)));

      repl_plru_tree #(.SET_ASSOC(SET_ASSOC)) u_lookup_tree (
        .tree_bits  (tree[lookup_set]),
        .victim     (policy_idx),
        .access_idx ('0),
        .next_bits  (lookup_next_unused)
      );

      repl_plru_tree #(.SET_ASSOC(SET_ASSOC)) u_update_tree (
        .tree_bits  (tree[update_set]),
        .victim     (update_victim_unused),
        .access_idx (acc_idx),
        .next_bits  (tree_next)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SET_NUM; s++) tree[s] <= '0;
        end else if (update && (|access)) begin
          tree[update_set] <= tree_next;
        end
      end
    end

    assign repl_index = (&way_valid) ? policy_idx
                                     : IDX_W'(first_zero(MAX_WAYS'(way_valid)));
  end

endmodule
